// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared definitions for the data-memory arbiter: Mem_Ctrl bit positions
//   and the arbiter FSM state encoding.
package dmem_arbiter_pkg;

  // Mem_Ctrl field positions (bits [3:2] carry nothing the arbiter uses)
  localparam int MC_RD = 0;
  localparam int MC_WR = 1;

  // Bits of Mem_Ctrl that constitute a request
  localparam logic [3:0] MC_REQ_MASK = (4'b0001 << MC_RD) | (4'b0001 << MC_WR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_select.sv
// rr_select
//   Combinational round-robin picker. Returns the first requesting index at
//   or after (last_grant + 1) mod NCORES, wrapping around.
//   Ports:
//     req        in   NCORES  one request bit per core
//     last_grant in   IW      index of the most recently served core
//     gnt_idx    out  IW      chosen core (0 when no request)
//     any_req    out  1       at least one request present
module rr_select #(
  parameter int NCORES = 4,
  parameter int IW     = $clog2(NCORES)
) (
  input  logic [NCORES-1:0] req,
  input  logic [IW-1:0]     last_grant,
  output logic [IW-1:0]     gnt_idx,
  output logic              any_req
);

  int idx;

  // Scan from the farthest offset down to the nearest one so that the
  // nearest requester after last_grant is the final (winning) assignment.
  always_comb begin
    idx     = 0;
    gnt_idx = '0;
    for (int k = NCORES; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NCORES;
      if (req[idx]) begin
        gnt_idx = idx[IW-1:0];
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous single-port data RAM between NCORES cores.
//   One transfer takes IDLE -> ACCESS -> ACK (3 cycles); the winner is
//   chosen round-robin, read data is broadcast on Ddin, and the served core
//   gets a one-cycle acq pulse.
//   Ports:
//     CLK, RST       clock, asynchronous active-high reset
//     core_memctrl   4 bits Mem_Ctrl per core (bit0 read, bit1 write)
//     core_addr      AW bits address per core
//     core_wdata     DW bits write data per core
//     acq            per-core completion pulse (ACK cycle)
//     Ddin           read data broadcast, valid with acq
//     mem_addr/mem_wdata/mem_wen  RAM request side
//     mem_rdata      RAM read data, valid the cycle after mem_addr
//     busy           FSM not in IDLE
//     grant_id       core currently being served
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int IW     = $clog2(NCORES)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [4*NCORES-1:0]  core_memctrl,
  input  logic [AW*NCORES-1:0] core_addr,
  input  logic [DW*NCORES-1:0] core_wdata,
  output logic [NCORES-1:0]    acq,
  output logic [DW-1:0]        Ddin,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_wen,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic [IW-1:0]        grant_id
);

  state_t          state_reg;
  logic [IW-1:0]   last_grant_reg;
  logic            write_reg;
  logic [DW-1:0]   ddin_reg;

  logic [NCORES-1:0] req;
  logic [NCORES-1:0] wr_req;
  logic [AW-1:0]     addr_arr  [NCORES];
  logic [DW-1:0]     wdata_arr [NCORES];
  logic [IW-1:0]     gnt_idx;
  logic              any_req;

  // Unpack the per-core buses into indexable arrays
  for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
    assign req[gi]       = |(core_memctrl[4*gi +: 4] & MC_REQ_MASK);
    assign wr_req[gi]    = core_memctrl[4*gi + MC_WR];
    assign addr_arr[gi]  = core_addr[gi*AW +: AW];
    assign wdata_arr[gi] = core_wdata[gi*DW +: DW];
  end

  rr_select #(
    .NCORES (NCORES),
    .IW     (IW)
  ) u_rr_select (
    .req        (req),
    .last_grant (last_grant_reg),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  // The RAM returns read data during ACK, the same cycle acq is high, so
  // the read value is forwarded straight through there; ddin_reg keeps it
  // afterwards and across write acknowledgements.
  assign Ddin = (state_reg == ACK && !write_reg) ? mem_rdata : ddin_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(NCORES - 1);
      write_reg      <= 1'b0;
      ddin_reg       <= '0;
      acq            <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_wen        <= 1'b0;
      busy           <= 1'b0;
      grant_id       <= '0;
    end else begin
      acq     <= '0;
      mem_wen <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            // Latch the whole request so the RAM side sees it in ACCESS
            grant_id  <= gnt_idx;
            write_reg <= wr_req[gnt_idx];
            mem_addr  <= addr_arr[gnt_idx];
            mem_wdata <= wdata_arr[gnt_idx];
            mem_wen   <= wr_req[gnt_idx];
            busy      <= 1'b1;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          acq[grant_id] <= 1'b1;
          state_reg     <= ACK;
        end
        ACK: begin
          if (!write_reg) begin
            ddin_reg <= mem_rdata;
          end
          last_grant_reg <= grant_id;
          busy           <= 1'b0;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: directed scenarios plus a random
//   traffic run checked against a transaction-level round-robin model.
module tb_dmem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic [4*N-1:0]  core_memctrl;
  logic [AW*N-1:0] core_addr;
  logic [DW*N-1:0] core_wdata;
  logic [N-1:0]    acq;
  logic [DW-1:0]   Ddin;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_wen;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [IW-1:0]   grant_id;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  dmem_arbiter #(.NCORES(N), .AW(AW), .DW(DW), .IW(IW)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .core_memctrl (core_memctrl),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .acq          (acq),
    .Ddin         (Ddin),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wen      (mem_wen),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 CLK = ~CLK;

  // Synchronous single-port RAM
  logic [DW-1:0] ram [256];
  always @(posedge CLK) begin
    mem_rdata <= ram[mem_addr];
    if (mem_wen) ram[mem_addr] = mem_wdata;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int c, input logic [3:0] mc, input logic [7:0] a, input logic [7:0] d);
    core_memctrl[4*c +: 4] = mc;
    core_addr[8*c +: 8]    = a;
    core_wdata[8*c +: 8]   = d;
  endtask

  task automatic clear_reqs();
    core_memctrl = '0;
    core_addr    = '0;
    core_wdata   = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_reqs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Advances until an acq pulse appears; core = -1 if none within the bound
  task automatic wait_acq(output int core, output int at);
    core = -1;
    at   = cyc;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acq != '0) begin
        for (int j = 0; j < N; j++) if (acq[j]) core = j;
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    for (int c = 0; c < N; c++) set_req(c, 4'b0001, 8'($urandom), 8'($urandom));
    tick();
    checks++;
    if ({acq, Ddin, mem_addr, mem_wdata, mem_wen, busy, grant_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got acq=%b Ddin=%h addr=%h wdata=%h wen=%b busy=%b gid=%0d exp all zero",
               acq, Ddin, mem_addr, mem_wdata, mem_wen, busy, grant_id);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_priority got gid=%0d busy=%b exp gid=0 busy=1", grant_id, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    do_reset();
    ram[8'h10] = 8'hA5;
    set_req(2, 4'b0001, 8'h10, 8'h00);
    tick();
    checks++;
    if (mem_addr !== 8'h10 || mem_wen !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL read_access got addr=%h wen=%b busy=%b exp addr=10 wen=0 busy=1", mem_addr, mem_wen, busy);
    end
    tick();
    checks++;
    if (acq !== 4'b0100 || Ddin !== 8'hA5) begin
      failures++;
      $display("FAIL read_ack got acq=%b Ddin=%h exp acq=0100 Ddin=a5", acq, Ddin);
    end
    tick();
    clear_reqs();
    checks++;
    if (acq !== 4'b0000) begin
      failures++;
      $display("FAIL read_acq_drop got acq=%b exp 0000", acq);
    end
    $display("test_single_read done");
  endtask

  task automatic test_single_write();
    int c, at;
    set_req(1, 4'b0010, 8'h20, 8'h3C);
    tick();
    checks++;
    if (mem_wen !== 1'b1 || mem_addr !== 8'h20 || mem_wdata !== 8'h3C) begin
      failures++;
      $display("FAIL write_access got wen=%b addr=%h wdata=%h exp wen=1 addr=20 wdata=3c", mem_wen, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if (acq !== 4'b0010 || Ddin !== 8'hA5 || mem_wen !== 1'b0) begin
      failures++;
      $display("FAIL write_ack got acq=%b Ddin=%h wen=%b exp acq=0010 Ddin=a5 wen=0", acq, Ddin, mem_wen);
    end
    tick();
    clear_reqs();
    set_req(1, 4'b0001, 8'h20, 8'h00);
    wait_acq(c, at);
    checks++;
    if (c !== 1 || Ddin !== 8'h3C) begin
      failures++;
      $display("FAIL write_readback got core=%0d Ddin=%h exp core=1 Ddin=3c", c, Ddin);
    end
    tick();
    clear_reqs();
    $display("test_single_write done");
  endtask

  task automatic test_round_robin();
    logic [7:0] vals [N];
    int c, at, prev_at;
    do_reset();
    prev_at = 0;
    for (int i = 0; i < N; i++) begin
      vals[i] = 8'($urandom);
      ram[64 + i] = vals[i];
      set_req(i, 4'b0001, 8'(64 + i), 8'h00);
    end
    for (int k = 0; k < 5; k++) begin
      wait_acq(c, at);
      checks++;
      if (c !== (k % N) || (c >= 0 && Ddin !== vals[c % N])) begin
        failures++;
        $display("FAIL rr_order k=%0d got core=%0d Ddin=%h exp core=%0d Ddin=%h", k, c, Ddin, k % N, vals[k % N]);
      end
      if (k > 0) begin
        checks++;
        if (at - prev_at != 3) begin
          failures++;
          $display("FAIL rr_spacing k=%0d got %0d cycles exp 3", k, at - prev_at);
        end
      end
      prev_at = at;
    end
    clear_reqs();
    tick();
    tick();
    $display("test_round_robin done");
  endtask

  task automatic test_wrap_skip();
    int c, at;
    do_reset();
    set_req(3, 4'b0001, 8'h00, 8'h00);
    wait_acq(c, at);
    checks++;
    if (c !== 3) begin
      failures++;
      $display("FAIL wrap_setup got core=%0d exp 3", c);
    end
    tick();
    clear_reqs();
    set_req(1, 4'b0001, 8'h01, 8'h00);
    set_req(3, 4'b0001, 8'h03, 8'h00);
    wait_acq(c, at);
    checks++;
    if (c !== 1) begin
      failures++;
      $display("FAIL wrap_first got core=%0d exp 1", c);
    end
    tick();
    set_req(1, 4'b0000, 8'h00, 8'h00);
    wait_acq(c, at);
    checks++;
    if (c !== 3) begin
      failures++;
      $display("FAIL wrap_second got core=%0d exp 3", c);
    end
    tick();
    clear_reqs();
    $display("test_wrap_skip done");
  endtask

  task automatic test_rw_both();
    int pulses;
    do_reset();
    pulses = 0;
    set_req(0, 4'b0011, 8'h55, 8'h99);
    tick();
    checks++;
    if (mem_wen !== 1'b1 || mem_addr !== 8'h55 || mem_wdata !== 8'h99) begin
      failures++;
      $display("FAIL rw_access got wen=%b addr=%h wdata=%h exp wen=1 addr=55 wdata=99", mem_wen, mem_addr, mem_wdata);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 1) clear_reqs();
      if (acq == 4'b0001) pulses++;
      else if (acq != 4'b0000) pulses += 10;
    end
    checks++;
    if (pulses != 1 || ram[8'h55] !== 8'h99) begin
      failures++;
      $display("FAIL rw_ack got pulses=%0d ram=%h exp pulses=1 ram=99", pulses, ram[8'h55]);
    end
    $display("test_rw_both done");
  endtask

  task automatic test_reset_mid();
    int c, at, stray;
    do_reset();
    set_req(0, 4'b0001, 8'h00, 8'h00);
    wait_acq(c, at);
    tick();
    clear_reqs();
    ram[8'h66] = 8'h11;
    set_req(2, 4'b0010, 8'h66, 8'hEE);
    tick();
    checks++;
    if (mem_wen !== 1'b1) begin
      failures++;
      $display("FAIL mid_access got wen=%b exp 1", mem_wen);
    end
    RST = 1'b1;
    #1;
    checks++;
    if (mem_wen !== 1'b0 || acq !== '0 || busy !== 1'b0 || grant_id !== '0) begin
      failures++;
      $display("FAIL mid_async got wen=%b acq=%b busy=%b gid=%0d exp all zero", mem_wen, acq, busy, grant_id);
    end
    clear_reqs();
    tick();
    tick();
    RST = 1'b0;
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (acq != '0) stray++;
    end
    checks++;
    if (stray != 0 || ram[8'h66] !== 8'h11) begin
      failures++;
      $display("FAIL mid_abandon got stray_acq=%0d ram=%h exp 0 and 11", stray, ram[8'h66]);
    end
    set_req(0, 4'b0001, 8'h00, 8'h00);
    set_req(1, 4'b0001, 8'h01, 8'h00);
    wait_acq(c, at);
    checks++;
    if (c !== 0) begin
      failures++;
      $display("FAIL mid_priority got core=%0d exp 0", c);
    end
    tick();
    clear_reqs();
    tick();
    tick();
    $display("test_reset_mid done");
  endtask

  // Random traffic; the model knows only the transaction rules: a choice is
  // made in an idle cycle among held requests, the RAM is touched one cycle
  // later, acq follows one cycle after that, and the next choice comes next.
  task automatic test_random();
    logic [7:0]   shadow [16];
    bit           pend [N];
    bit           kwr [N];
    logic [7:0]   ka [N];
    logic [7:0]   kd [N];
    logic [N-1:0] exp_acq;
    logic [7:0]   model_ddin, ga, gd;
    logic [3:0]   mc;
    int           ph, g, last, rel, cnt;
    bit           gw;
    do_reset();
    for (int a = 0; a < 16; a++) begin
      shadow[a] = 8'($urandom);
      ram[a]    = shadow[a];
    end
    ph = 0; g = 0; last = N - 1; rel = -1; cnt = 0;
    gw = 1'b0; ga = '0; gd = '0; model_ddin = '0;
    for (int c = 0; c < N; c++) begin
      pend[c] = 1'b0; kwr[c] = 1'b0; ka[c] = '0; kd[c] = '0;
    end
    for (int t = 0; t < 400; t++) begin
      if (rel >= 0) pend[rel] = 1'b0;
      for (int c = 0; c < N; c++) begin
        if (!pend[c]) begin
          mc = {2'($urandom), 2'b00};
          if ($urandom_range(0, 2) == 0) begin
            pend[c] = 1'b1;
            kwr[c]  = 1'($urandom_range(0, 1));
            ka[c]   = 8'($urandom_range(0, 15));
            kd[c]   = 8'($urandom);
            mc[1:0] = kwr[c] ? 2'(2 + $urandom_range(0, 1)) : 2'b01;
            set_req(c, mc, ka[c], kd[c]);
          end else begin
            set_req(c, mc, 8'($urandom), 8'($urandom));
          end
        end
      end
      exp_acq = '0;
      if (ph == 2) exp_acq[g] = 1'b1;
      checks++;
      if (acq !== exp_acq) begin
        failures++;
        $display("FAIL rand_acq t=%0d got %b exp %b", t, acq, exp_acq);
      end
      checks++;
      if (busy !== (ph != 0)) begin
        failures++;
        $display("FAIL rand_busy t=%0d got %b exp %b", t, busy, ph != 0);
      end
      if (ph == 1) begin
        checks++;
        if (mem_wen !== gw || mem_addr !== ga || (gw && mem_wdata !== gd)) begin
          failures++;
          $display("FAIL rand_access t=%0d got wen=%b addr=%h wdata=%h exp wen=%b addr=%h wdata=%h",
                   t, mem_wen, mem_addr, mem_wdata, gw, ga, gd);
        end
      end
      if (ph == 2) begin
        if (!gw) model_ddin = shadow[ga[3:0]];
        checks++;
        if (Ddin !== model_ddin) begin
          failures++;
          $display("FAIL rand_ddin t=%0d core=%0d got %h exp %h", t, g, Ddin, model_ddin);
        end
        cnt++;
      end
      rel = -1;
      case (ph)
        0: begin
          for (int k = N; k >= 1; k--) begin
            if (pend[(last + k) % N]) begin
              g = (last + k) % N;
              ph = 1;
            end
          end
          if (ph == 1) begin
            gw = kwr[g]; ga = ka[g]; gd = kd[g];
          end
        end
        1: begin
          if (gw) shadow[ga[3:0]] = gd;
          ph = 2;
        end
        default: begin
          last = g;
          rel  = g;
          ph   = 0;
        end
      endcase
      tick();
    end
    clear_reqs();
    tick();
    tick();
    tick();
    $display("test_random done transfers=%0d", cnt);
  endtask

  initial begin
    RST = 1'b1;
    clear_reqs();
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_wrap_skip();
    test_rw_both();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
